// File: rtl/tdm_demux18.sv
// Receive side of the 8:1 TDM serial link: rebuilds 8 parallel channels from the
// slot-scanned bit stream, aligned by a start-of-frame marker with HUNT/LOCK sync tracking.
module tdm_demux18 #(
  parameter int unsigned SYNC_MISS_MAX = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       sof,
  output logic       o0,
  output logic       o1,
  output logic       o2,
  output logic       o3,
  output logic       o4,
  output logic       o5,
  output logic       o6,
  output logic       o7,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err,
  output logic [2:0] slot
);

  localparam int unsigned SLOT_W = 3;
  localparam int unsigned MISS_W = 3;
  localparam int unsigned NCH    = 8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [MISS_W-1:0]   miss_q, miss_d;
  logic [MISS_W-1:0]   miss_inc;
  logic                miss_limit;
  logic [NCH-1:0]      shadow_q, shadow_d;
  logic [NCH-1:0]      out_q, out_d;
  logic                fv_q, fv_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;

  assign miss_inc   = MISS_W'(miss_q + MISS_W'(1));
  assign miss_limit = (miss_inc == MISS_W'(SYNC_MISS_MAX));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      miss_q   <= '0;
      shadow_q <= '0;
      out_q    <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      miss_q   <= miss_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  // Sync state transitions
  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      case (state_q)
        HUNT:    if (sof) state_d = LOCK;
        LOCK:    if ((slot_q == '0) && !sof && miss_limit) state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  // Slot capture, frame completion and pulse generation
  always_comb begin
    slot_d   = slot_q;
    miss_d   = miss_q;
    shadow_d = shadow_q;
    out_d    = out_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    locked_d = (state_d == LOCK);
    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (sof) begin
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
            miss_d      = '0;
          end
        end
        LOCK: begin
          if (slot_q != '0) begin
            if (sof) begin
              // Early marker: restart the frame on this beat
              err_d       = 1'b1;
              shadow_d[0] = din;
              slot_d      = SLOT_W'(1);
              miss_d      = '0;
            end else begin
              shadow_d[slot_q] = din;
              slot_d           = SLOT_W'(slot_q + SLOT_W'(1));
              if (slot_q == SLOT_W'(NCH - 1)) begin
                out_d = {din, shadow_q[NCH-2:0]};
                fv_d  = 1'b1;
              end
            end
          end else if (sof) begin
            shadow_d[0] = din;
            slot_d      = SLOT_W'(1);
            miss_d      = '0;
          end else begin
            // Missing marker: flywheel until the miss budget is spent
            err_d = 1'b1;
            if (miss_limit) begin
              slot_d = '0;
              miss_d = '0;
            end else begin
              shadow_d[0] = din;
              slot_d      = SLOT_W'(1);
              miss_d      = miss_inc;
            end
          end
        end
        default: begin
          slot_d = '0;
          miss_d = '0;
        end
      endcase
    end
  end

  assign {o7, o6, o5, o4, o3, o2, o1, o0} = out_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = locked_q;
  assign slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux18.sv
// Scoreboard bench for tdm_demux18: expected frames are queued as completion beats are
// driven and compared whenever frame_valid fires.
module tb_tdm_demux18;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic       sof;
  logic       o0, o1, o2, o3, o4, o5, o6, o7;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;
  logic [2:0] slot;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned fv_cnt = 0;
  int unsigned err_cnt = 0;
  logic [7:0]  sb_q[$];

  tdm_demux18 #(.SYNC_MISS_MAX(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
    .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err), .slot(slot)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {o7, o6, o5, o4, o3, o2, o1, o0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every frame_valid pulse must match the oldest queued frame
  always @(negedge clk) begin
    if (!rst) begin
      if (sync_err) err_cnt++;
      if (frame_valid) begin
        fv_cnt++;
        if (sb_q.size() == 0) chk("fv_unexpected", 32'(outs()), 32'hFFFF_FFFF);
        else chk("frame", 32'(outs()), 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic beat(input logic d, input logic s);
    din = d; sof = s; din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0; din = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send beats first..7 of a frame; queue the expected frame before the completion beat
  task automatic send_frame(input logic [7:0] bits, input logic first_sof, input int first,
                            input bit gaps);
    logic [2:0] s_hold;
    for (int k = first; k < 8; k++) begin
      if (k == 7) sb_q.push_back(bits);
      beat(bits[k], first_sof && (k == first));
      if (gaps && k < 7) begin
        s_hold = slot;
        idle(int'($urandom_range(3, 1)));
        chk("slot_frozen", 32'(slot), 32'(s_hold));
      end
    end
  endtask

  int unsigned fv0, er0;
  logic [7:0] fa, fb, fc, fd;

  initial begin
    rst = 1'b1; din = 1'b1; din_valid = 1'b1; sof = 1'b1;
    // 1: reset dominates an active sof beat
    idle(3);
    chk("rst_outs", 32'(outs()), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_err", 32'(sync_err), 32'h0);
    chk("rst_slot", 32'(slot), 32'h0);
    rst = 1'b0; din_valid = 1'b0; sof = 1'b0; din = 1'b0;
    idle(2);
    chk("post_rst_locked", 32'(locked), 32'h0);

    // 2: clean frame o0..o7 = 1,0,1,1,0,0,1,0
    fa = 8'b0100_1101;
    fv0 = fv_cnt;
    beat(fa[0], 1'b1);
    chk("lock_after_b1", 32'(locked), 32'h1);
    chk("slot_after_b1", 32'(slot), 32'h1);
    send_frame(fa, 1'b0, 1, 1'b0);
    chk("fv_pulse", 32'(frame_valid), 32'h1);
    chk("outs_clean", 32'(outs()), 32'(fa));
    idle(1);
    chk("fv_one_cycle", 32'(frame_valid), 32'h0);
    chk("fv_count_t2", fv_cnt - fv0, 32'h1);

    // 3: same data with idle gaps of 1-3 cycles
    fv0 = fv_cnt; er0 = err_cnt;
    send_frame(fa, 1'b1, 0, 1'b1);
    idle(2);
    chk("outs_gaps", 32'(outs()), 32'(fa));
    chk("fv_count_t3", fv_cnt - fv0, 32'h1);
    chk("err_count_t3", err_cnt - er0, 32'h0);

    // 4: early sof on beat 5, then a full frame from that sof
    fb = 8'b1110_0010;
    fv0 = fv_cnt; er0 = err_cnt;
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    beat(fb[0], 1'b1);
    chk("early_sof_err", 32'(sync_err), 32'h1);
    chk("early_sof_slot", 32'(slot), 32'h1);
    send_frame(fb, 1'b0, 1, 1'b0);
    idle(1);
    chk("outs_resync", 32'(outs()), 32'(fb));
    chk("fv_count_t4", fv_cnt - fv0, 32'h1);
    chk("err_count_t4", err_cnt - er0, 32'h1);

    // 5: two frames without sof; first flywheels, second drops to HUNT
    fc = 8'b0011_0110;
    fv0 = fv_cnt; er0 = err_cnt;
    send_frame(fc, 1'b0, 0, 1'b0);
    idle(1);
    chk("flywheel_outs", 32'(outs()), 32'(fc));
    chk("flywheel_locked", 32'(locked), 32'h1);
    beat(1'b1, 1'b0);
    chk("miss2_err", 32'(sync_err), 32'h1);
    chk("miss2_unlocked", 32'(locked), 32'h0);
    chk("miss2_slot", 32'(slot), 32'h0);
    for (int k = 1; k < 8; k++) beat(1'(k), 1'b0);
    idle(1);
    chk("hunt_slot", 32'(slot), 32'h0);
    chk("hunt_hold_outs", 32'(outs()), 32'(fc));
    chk("fv_count_t5", fv_cnt - fv0, 32'h1);
    chk("err_count_t5", err_cnt - er0, 32'h2);
    fd = 8'b1001_1011;
    send_frame(fd, 1'b1, 0, 1'b0);
    idle(1);
    chk("relock_outs", 32'(outs()), 32'(fd));
    chk("relock_locked", 32'(locked), 32'h1);

    // 6: reset mid-frame discards it; clean frame afterwards
    fv0 = fv_cnt;
    for (int k = 0; k < 4; k++) beat(1'b1, k == 0);
    rst = 1'b1;
    idle(2);
    chk("rst6_outs", 32'(outs()), 32'h0);
    chk("rst6_locked", 32'(locked), 32'h0);
    chk("rst6_fv", 32'(frame_valid), 32'h0);
    rst = 1'b0;
    idle(1);
    send_frame(fa, 1'b1, 0, 1'b0);
    idle(1);
    chk("post_rst6_outs", 32'(outs()), 32'(fa));
    chk("fv_count_t6", fv_cnt - fv0, 32'h1);

    idle(2);
    chk("sb_leftover", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
